// File: rtl/edge_seq_pkg.sv
// -----------------------------------------------------------------------------
// edge_seq_pkg
// Shared definitions for the edge-detector frame sequencer:
//   - state encodings (4-bit internal; the low three bits form the debug
//     state_o view, where only ERROR maps to 7)
//   - stage indices into the stage_done / begin_* vectors
//   - address-width helper
// -----------------------------------------------------------------------------
package edge_seq_pkg;

  localparam int STAGE_COUNT   = 5;
  localparam int STG_GAUSS     = 0;
  localparam int STG_SOBEL     = 1;
  localparam int STG_STRENGTH  = 2;
  localparam int STG_DIRECTION = 3;
  localparam int STG_HYST      = 4;

  localparam int DEF_IMG_WIDTH  = 16;
  localparam int DEF_IMG_HEIGHT = 16;

  // Width of a counter that indexes n positions, never less than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ADDR_X_W = addr_width(DEF_IMG_WIDTH);
  localparam int DEF_ADDR_Y_W = addr_width(DEF_IMG_HEIGHT);

  // DONE lives above the 3-bit range so ERROR alone reports state_o = 7;
  // DONE shows up on state_o as 0 for its single cycle.
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD      = 4'd1;
  localparam logic [3:0] ST_GAUSS     = 4'd2;
  localparam logic [3:0] ST_SOBEL     = 4'd3;
  localparam logic [3:0] ST_STRENGTH  = 4'd4;
  localparam logic [3:0] ST_DIRECTION = 4'd5;
  localparam logic [3:0] ST_HYST      = 4'd6;
  localparam logic [3:0] ST_ERROR     = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  typedef enum logic [3:0] {
    SEQ_IDLE      = ST_IDLE,
    SEQ_LOAD      = ST_LOAD,
    SEQ_GAUSS     = ST_GAUSS,
    SEQ_SOBEL     = ST_SOBEL,
    SEQ_STRENGTH  = ST_STRENGTH,
    SEQ_DIRECTION = ST_DIRECTION,
    SEQ_HYST      = ST_HYST,
    SEQ_ERROR     = ST_ERROR,
    SEQ_DONE      = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/edge_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// edge_seq_addr_gen
// Raster-order x/y address counter for the convolution image buffer.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   clear             force both addresses to 0 (wins over advance)
//   advance           step one pixel in raster order
//   addr_x, addr_y    current column / row
//   last              current address is the final pixel of the frame
// -----------------------------------------------------------------------------
module edge_seq_addr_gen #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          advance,
  output logic [$clog2(IMG_WIDTH)-1:0]  addr_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] addr_y,
  output logic                          last
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);

  logic x_at_end;
  logic y_at_end;

  assign x_at_end = (addr_x == X_MAX);
  assign y_at_end = (addr_y == Y_MAX);
  assign last     = x_at_end && y_at_end;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      addr_x <= '0;
      addr_y <= '0;
    end else if (advance) begin
      if (x_at_end) begin
        addr_x <= '0;
        // Wrapping y at the last pixel leaves the counter at (0,0) for the
        // next frame without a separate clear.
        addr_y <= y_at_end ? '0 : addr_y + 1'b1;
      end else begin
        addr_x <= addr_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// edge_pipeline_sequencer
// Frame-level controller for the edge-detector datapath. Loads one frame of
// grayscale pixels into the image buffer (generating write addresses), then
// fires Gaussian, Sobel, strength, direction and hysteresis stages in order,
// waiting on each stage's done pulse, and reports frame completion.
//
// Optional feature: define EDGE_SEQ_TIMEOUT_EN to add a per-stage watchdog.
// A stage running TIMEOUT_CYCLES cycles without its done pulse sends the
// sequencer to ERROR with a sticky error flag. Without the macro ERROR is
// unreachable and stages wait indefinitely.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, abort          host frame start / cancel
//   pixel_valid/pixel_in  upstream pixel stream; pixel_ready accepts in LOAD
//   wr_en/wr_data         image buffer write strobe and data
//   addr_x/addr_y         image buffer write address
//   stage_done[4:0]       stage done pulses (gauss, sobel, strength, dir, hyst)
//   begin_*               one-cycle stage start pulses
//   begin_write           high in LOAD
//   begin_convolution     high in GAUSS and SOBEL
//   busy                  high outside IDLE and ERROR
//   frame_done            one-cycle completion pulse
//   error                 sticky stage-timeout flag
//   state_o               3-bit debug view of the state
// -----------------------------------------------------------------------------
module edge_pipeline_sequencer
  import edge_seq_pkg::*;
#(
  parameter int IMG_WIDTH      = 16,
  parameter int IMG_HEIGHT     = 16,
  parameter int COLDepth       = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          pixel_valid,
  input  logic [COLDepth-1:0]           pixel_in,
  output logic                          pixel_ready,
  output logic                          wr_en,
  output logic [COLDepth-1:0]           wr_data,
  output logic [$clog2(IMG_WIDTH)-1:0]  addr_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] addr_y,
  input  logic [STAGE_COUNT-1:0]        stage_done,
  output logic                          begin_write,
  output logic                          begin_convolution,
  output logic                          begin_gauss,
  output logic                          begin_sobel,
  output logic                          begin_strength,
  output logic                          begin_direction,
  output logic                          begin_hysteresis,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          error,
  output logic [2:0]                    state_o
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       entry_q;     // first cycle in the current state
  logic       last_pixel;
  logic       timeout;
  logic       fire;        // entry cycle of a stage, not being aborted

  // ---------------------------------------------------------------------------
  // Pixel load path
  // ---------------------------------------------------------------------------
  assign pixel_ready = (state_q == ST_LOAD);
  assign wr_en       = pixel_valid && pixel_ready;
  assign wr_data     = pixel_ready ? pixel_in : '0;

  // Addresses sit at (0,0) whenever not loading, so any entry into LOAD
  // starts from the origin.
  edge_seq_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (!pixel_ready || abort),
    .advance (wr_en),
    .addr_x  (addr_x),
    .addr_y  (addr_y),
    .last    (last_pixel)
  );

  // ---------------------------------------------------------------------------
  // Optional stage watchdog
  // ---------------------------------------------------------------------------
`ifdef EDGE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] stage_cnt_q;
  logic          in_stage;

  assign in_stage = (state_q >= ST_GAUSS) && (state_q <= ST_HYST);
  // Counter reads k on the k-th cycle after entry, so the final allowed
  // cycle is TIMEOUT_CYCLES-1 and ERROR follows on the next edge.
  assign timeout  = in_stage && (stage_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign error    = (state_q == ST_ERROR);

  always_ff @(posedge clk) begin
    if (reset || (state_d != state_q)) begin
      stage_cnt_q <= '0;
    end else if (in_stage) begin
      stage_cnt_q <= stage_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
  assign error              = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic. Abort outranks everything, including start in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default hold assignment first means every path assigns
    // state_d, so no latch is inferred.
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (start) state_d = ST_LOAD;
        ST_LOAD:      if (wr_en && last_pixel) state_d = ST_GAUSS;
        ST_GAUSS:     if (stage_done[STG_GAUSS]) state_d = ST_SOBEL;
                      else if (timeout) state_d = ST_ERROR;
        ST_SOBEL:     if (stage_done[STG_SOBEL]) state_d = ST_STRENGTH;
                      else if (timeout) state_d = ST_ERROR;
        ST_STRENGTH:  if (stage_done[STG_STRENGTH]) state_d = ST_DIRECTION;
                      else if (timeout) state_d = ST_ERROR;
        ST_DIRECTION: if (stage_done[STG_DIRECTION]) state_d = ST_HYST;
                      else if (timeout) state_d = ST_ERROR;
        ST_HYST:      if (stage_done[STG_HYST]) state_d = ST_DONE;
                      else if (timeout) state_d = ST_ERROR;
        ST_DONE:      state_d = ST_IDLE;
        ST_ERROR:     if (start) state_d = ST_LOAD;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fire = entry_q && !abort;

  assign begin_gauss       = fire && (state_q == ST_GAUSS);
  assign begin_sobel       = fire && (state_q == ST_SOBEL);
  assign begin_strength    = fire && (state_q == ST_STRENGTH);
  assign begin_direction   = fire && (state_q == ST_DIRECTION);
  assign begin_hysteresis  = fire && (state_q == ST_HYST);

  assign begin_write       = (state_q == ST_LOAD);
  assign begin_convolution = (state_q == ST_GAUSS) || (state_q == ST_SOBEL);
  assign busy              = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign frame_done        = (state_q == ST_DONE);
  assign state_o           = state_q[2:0];

endmodule

// File: tb/tb_edge_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_edge_pipeline_sequencer
// Scoreboard bench for edge_pipeline_sequencer at W=4, H=4. Stimulus pushes
// the expected output events (buffer writes, begin pulses, frame_done) into a
// queue; a monitor on the falling edge pops and compares every event the DUT
// emits. Direct checks cover state, address and flag values at key cycles.
// -----------------------------------------------------------------------------
module tb_edge_pipeline_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CD = 8;

  localparam logic [2:0] K_WR    = 3'd0;
  localparam logic [2:0] K_GAUSS = 3'd1;
  localparam logic [2:0] K_FDONE = 3'd6;

  typedef struct packed {
    logic [2:0] kind;
    logic [1:0] x;
    logic [1:0] y;
    logic [7:0] data;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          pixel_valid;
  logic [CD-1:0] pixel_in;
  logic          pixel_ready;
  logic          wr_en;
  logic [CD-1:0] wr_data;
  logic [1:0]    addr_x;
  logic [1:0]    addr_y;
  logic [4:0]    stage_done;
  logic          begin_write;
  logic          begin_convolution;
  logic          begin_gauss;
  logic          begin_sobel;
  logic          begin_strength;
  logic          begin_direction;
  logic          begin_hysteresis;
  logic          busy;
  logic          frame_done;
  logic          error;
  logic [2:0]    state_o;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_count = 0;
  ev_t exp_q[$];

  logic [26:0] all_outs;
  assign all_outs = {pixel_ready, wr_en, wr_data, addr_x, addr_y, begin_write,
                     begin_convolution, begin_gauss, begin_sobel, begin_strength,
                     begin_direction, begin_hysteresis, busy, frame_done, error,
                     state_o};

  edge_pipeline_sequencer #(
    .IMG_WIDTH      (W),
    .IMG_HEIGHT     (H),
    .COLDepth       (CD),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .pixel_valid       (pixel_valid),
    .pixel_in          (pixel_in),
    .pixel_ready       (pixel_ready),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .addr_x            (addr_x),
    .addr_y            (addr_y),
    .stage_done        (stage_done),
    .begin_write       (begin_write),
    .begin_convolution (begin_convolution),
    .begin_gauss       (begin_gauss),
    .begin_sobel       (begin_sobel),
    .begin_strength    (begin_strength),
    .begin_direction   (begin_direction),
    .begin_hysteresis  (begin_hysteresis),
    .busy              (busy),
    .frame_done        (frame_done),
    .error             (error),
    .state_o           (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic ev_t mk(input logic [2:0] k, input int x, input int y, input int d);
    ev_t e;
    e.kind = k;
    e.x    = 2'(x);
    e.y    = 2'(y);
    e.data = 8'(d);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic observe(input ev_t got);
    ev_t want;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind=%0d x=%0d y=%0d data=%0h expected no event (t=%0t)",
               got.kind, got.x, got.y, got.data, $time);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_bad++;
        $display("FAIL event: got kind=%0d x=%0d y=%0d data=%0h expected kind=%0d x=%0d y=%0d data=%0h (t=%0t)",
                 got.kind, got.x, got.y, got.data, want.kind, want.x, want.y, want.data, $time);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        wr_count++;
        observe(mk(K_WR, int'(addr_x), int'(addr_y), int'(wr_data)));
      end
      if (begin_gauss)      observe(mk(3'd1, 0, 0, 0));
      if (begin_sobel)      observe(mk(3'd2, 0, 0, 0));
      if (begin_strength)   observe(mk(3'd3, 0, 0, 0));
      if (begin_direction)  observe(mk(3'd4, 0, 0, 0));
      if (begin_hysteresis) observe(mk(3'd5, 0, 0, 0));
      if (frame_done)       observe(mk(K_FDONE, 0, 0, 0));
    end
  end

  // Pulse start from IDLE; leaves the bench on the first LOAD cycle.
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("load entry state", 32'(state_o), 1);
    check("load begin_write", 32'(begin_write), 1);
  endtask

  // Load a full 4x4 frame; throttle inserts a dead cycle after each pixel.
  // Ends on the GAUSS entry cycle.
  task automatic load_frame(input int base, input bit throttle);
    for (int i = 0; i < W * H; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'(base + i);
      exp_q.push_back(mk(K_WR, i % W, i / W, base + i));
      if (i == W * H - 1) exp_q.push_back(mk(K_GAUSS, 0, 0, 0));
      step();
      pixel_valid = 1'b0;
      if (throttle && i < W * H - 1) begin
        step();
        check("stall addr", 32'({addr_y, addr_x}), 32'(((i + 1) / W) * 4 + (i + 1) % W));
      end
    end
    check("gauss entry state", 32'(state_o), 2);
    check("gauss pixel_ready", 32'(pixel_ready), 0);
    check("gauss addr cleared", 32'({addr_y, addr_x}), 0);
  endtask

  // From the entry cycle of stage idx, return its done after `delay` cycles.
  task automatic run_stage(input int idx, input int delay);
    check("stage entry state", 32'(state_o), 32'(2 + idx));
    repeat (delay) step();
    stage_done = 5'(1 << idx);
    exp_q.push_back(mk((idx < 4) ? 3'(K_GAUSS + idx + 1) : K_FDONE, 0, 0, 0));
    step();
    stage_done = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    stage_done  = '0;
    repeat (3) step();
    check("reset outputs", 32'(all_outs), 0);
    reset = 1'b0;
    step();

    // start together with abort in IDLE stays in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start+abort idle", 32'(state_o), 0);
    check("start+abort busy", 32'(busy), 0);

    // Frame 1: back-to-back load, each done 2 cycles after its begin
    do_start();
    load_frame(8'h10, 1'b0);
    for (int s = 0; s < 5; s++) run_stage(s, 2);
    check("done frame_done", 32'(frame_done), 1);
    check("done busy", 32'(busy), 1);
    step();
    check("post-frame busy", 32'(busy), 0);
    check("post-frame state", 32'(state_o), 0);
    check("frame1 writes", 32'(wr_count), 16);

    // Frame 2: throttled load, mixed done latencies incl. entry-cycle done
    do_start();
    load_frame(8'h40, 1'b1);
    run_stage(0, 0);
    run_stage(1, 1);
    run_stage(2, 0);
    run_stage(3, 3);
    run_stage(4, 0);
    check("frame2 frame_done", 32'(frame_done), 1);
    step();
    check("frame2 writes", 32'(wr_count), 32);

    // Frame 3: wrong-stage done ignored, then abort beats a done
    do_start();
    load_frame(8'h80, 1'b0);
    run_stage(0, 2);
    check("sobel entry", 32'(state_o), 3);
    step();
    stage_done = 5'b01000;
    step();
    stage_done = '0;
    check("foreign done ignored", 32'(state_o), 3);
    check("sobel convolution", 32'(begin_convolution), 1);
    run_stage(1, 0);
    check("strength entry", 32'(state_o), 4);
    step();
    step();
    stage_done = 5'b00100;
    abort      = 1'b1;
    step();
    stage_done = '0;
    abort      = 1'b0;
    check("abort state", 32'(state_o), 0);
    check("abort begin_direction", 32'(begin_direction), 0);
    check("abort frame_done", 32'(frame_done), 0);
    check("abort busy", 32'(busy), 0);
    repeat (3) step();
    check("abort no pending", 32'(exp_q.size()), 0);

    // Reset mid-load after 7 pixels, then a clean reload from (0,0)
    do_start();
    for (int i = 0; i < 7; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'(8'hA0 + i);
      exp_q.push_back(mk(K_WR, i % W, i / W, 8'hA0 + i));
      step();
    end
    pixel_valid = 1'b0;
    check("mid-load addr", 32'({addr_y, addr_x}), 32'(4 + 3));
    reset    = 1'b1;
    pixel_in = 8'h5A;
    step();
    reset = 1'b0;
    check("mid-load reset outputs", 32'(all_outs), 0);
    do_start();
    load_frame(8'hC0, 1'b0);
    for (int s = 0; s < 5; s++) run_stage(s, 1);
    check("reload frame_done", 32'(frame_done), 1);
    step();

`ifdef EDGE_SEQ_TIMEOUT_EN
    // Timeout: GAUSS never completes
    do_start();
    load_frame(8'h20, 1'b0);
    repeat (7) step();
    check("timeout still gauss", 32'(state_o), 2);
    check("timeout error low", 32'(error), 0);
    step();
    check("timeout error state", 32'(state_o), 7);
    check("timeout error flag", 32'(error), 1);
    check("timeout busy", 32'(busy), 0);
    step();
    check("timeout error sticky", 32'(error), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart load", 32'(state_o), 1);
    check("restart error clear", 32'(error), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("restart abort idle", 32'(state_o), 0);
`else
    check("error tied low", 32'(error), 0);
`endif

    step();
    check("all events seen", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_pipeline_sequencer.md
Name: edge_pipeline_sequencer

Overview:
- Frame-level controller for the edge-detector datapath.
- Accepts a grayscale pixel stream into the convolution image buffer, generating the write addresses.
- Then fires each stage in order: Gaussian, Sobel, gradient strength, gradient direction, hysteresis.
- Waits for each stage's done pulse before advancing, and reports frame completion or failure to the host.

Parameters:
- IMG_WIDTH, 16, pixels per row.
- IMG_HEIGHT, 16, rows per frame.
- COLDepth, 8, pixel bit width.
- TIMEOUT_CYCLES, 65535, maximum cycles a stage may run before being flagged (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE or ERROR.
- abort  in  1  cancel current frame; returns to IDLE next cycle.
- pixel_valid  in  1  upstream pixel present.
- pixel_in  in  COLDepth  grayscale pixel.
- pixel_ready  out  1  sequencer accepts pixel this cycle.
- wr_en  out  1  buffer write strobe (pixel_valid & pixel_ready).
- wr_data  out  COLDepth  pixel_in passthrough.
- addr_x  out  $clog2(IMG_WIDTH)  column address.
- addr_y  out  $clog2(IMG_HEIGHT)  row address.
- stage_done  in  5  per-stage one-cycle done pulses; bit0 gauss, 1 sobel, 2 strength, 3 direction, 4 hysteresis.
- begin_write  out  1  level, high in LOAD.
- begin_convolution  out  1  level, high in GAUSS and SOBEL states.
- begin_gauss, begin_sobel, begin_strength, begin_direction, begin_hysteresis  out  1 each  one-cycle start pulses.
- busy  out  1  high in any state except IDLE and ERROR.
- frame_done  out  1  one-cycle completion pulse.
- error  out  1  sticky stage-timeout flag.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0. addr_x/addr_y 0. Counters 0.
- States: IDLE, LOAD, GAUSS, SOBEL, STRENGTH, DIRECTION, HYST, DONE, ERROR (3-bit encoding; ERROR shares state_o=7 with no other state).
- IDLE: start=1 -> LOAD next cycle; addresses cleared to 0.
- LOAD:
  - pixel_ready=1; each accepted pixel writes at (addr_x, addr_y).
  - addr_x increments; at IMG_WIDTH-1 it wraps to 0 and addr_y increments.
  - The transfer at (IMG_WIDTH-1, IMG_HEIGHT-1) is the last. The next cycle is GAUSS, with pixel_ready=0 and addresses cleared to 0.
  - pixel_valid=0 stalls without advancing.
- Stage states GAUSS..HYST:
  - On the entry cycle, the matching begin_* pulse is high for exactly 1 cycle.
  - The sequencer then waits for its own stage_done bit. That bit -> next stage state on the next cycle.
  - Done bits belonging to other stages are ignored.
  - A done pulse on the entry cycle itself is accepted.
- HYST done -> DONE. DONE lasts 1 cycle with frame_done=1, then IDLE.
- Latency: a minimum frame takes 1 (IDLE->LOAD) + W*H + 5 stages x 1 + 1 DONE cycles.
- abort=1 in any non-IDLE state -> IDLE next cycle.
  - No begin pulse is issued on that cycle; abort has priority over a simultaneous done or last pixel.
  - abort in IDLE has no effect.
- start outside IDLE/ERROR is ignored; start together with abort resolves to abort.
- Reset mid-frame behaves identically to power-on reset.

Optional Feature:
- Macro EDGE_SEQ_TIMEOUT_EN.
- Defined:
  - A per-stage cycle counter clears on every stage entry.
  - If it reaches TIMEOUT_CYCLES without the matching done pulse, the state goes to ERROR next cycle and error=1.
  - error stays set until start (which clears error and enters LOAD) or reset; abort from ERROR -> IDLE with error cleared.
- Undefined: no counter, ERROR is unreachable, error tied to 0, and stages wait indefinitely.

Decomposition:
- Package edge_seq_pkg:
  - seq_state_t enum.
  - Stage index localparams STG_GAUSS=0 .. STG_HYST=4.
  - STAGE_COUNT=5.
  - Address-width helper constants.
- One sub-module, edge_seq_addr_gen: raster x/y counter with clear, advance, and last-pixel flag, parameterised by IMG_WIDTH and IMG_HEIGHT.

Test Plan:
- W=4,H=4; start, 16 back-to-back pixels, each stage_done returned 2 cycles after its begin -> addresses 0..3 per row across 4 rows, begin pulses in order gauss, sobel, strength, direction, hysteresis, then frame_done 1 cycle, busy low after.
- Throttled load: pixel_valid toggles 1,0,1,0 -> only 16 wr_en pulses; addresses advance only on transfers; GAUSS is entered 1 cycle after the 16th transfer.
- Out-of-order done: in SOBEL, pulse stage_done[3] -> ignored, state stays SOBEL; then stage_done[1] -> STRENGTH.
- abort asserted in the same cycle as stage_done[2] in STRENGTH -> IDLE next cycle, no begin_direction, no frame_done.
- Timeout with EDGE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8: hold stage_done=0 in GAUSS -> ERROR after 8 cycles, error=1; start -> LOAD with error=0.
- Synchronous reset asserted mid-LOAD at pixel 7 -> next cycle IDLE, addresses 0, all outputs 0; a new start reloads from (0,0).
